// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/owner encodings and default widths for the cache-to-memory arbiter
package mem_arbiter_pkg;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick between the I-cache and D-cache requesters
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last,
    output logic   grant_valid,
    output owner_t grant_owner
);
    always_comb begin
        grant_valid = req_i | req_d;
        grant_owner = (req_i && req_d) ? ((last == OWN_I) ? OWN_D : OWN_I) : (req_d ? OWN_D : OWN_I);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-memory bus between the I-cache and D-cache miss engines
module mem_arbiter #(
    parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
    parameter int DATA_W = mem_arbiter_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ren,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);
    import mem_arbiter_pkg::*;

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    owner_t            last;
    owner_t            grant_owner;
    logic              grant_valid;
    logic              grant;
    logic              accept;
    logic              sel_d;
    logic              g_ren;
    logic              g_wen;
    logic [DATA_W-1:0] rdata_q;

    rr_pick2 u_pick (
        .req_i       (i_ren | i_wen),
        .req_d       (d_ren | d_wen),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // A write wins over a read when a requester raises both strobes
    always_comb begin
        grant      = (state == IDLE) && grant_valid;
        accept     = (state == BUSY) && mem_ready;
        sel_d      = grant_owner == OWN_D;
        g_wen      = sel_d ? d_wen : i_wen;
        g_ren      = (sel_d ? d_ren : i_ren) & ~g_wen;
        state_next = (state == DONE) ? IDLE : (state == BUSY) ? (mem_ready ? DONE : BUSY) : (grant ? BUSY : IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            last      <= OWN_I;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state   <= state_next;
            i_ready <= accept && (owner == OWN_I);
            d_ready <= accept && (owner == OWN_D);
            if (grant) begin
                owner     <= grant_owner;
                last      <= grant_owner;
                mem_addr  <= sel_d ? d_addr : i_addr;
                mem_wdata <= sel_d ? d_wdata : i_wdata;
                mem_ren   <= g_ren;
                mem_wen   <= g_wen;
            end
            if (accept) begin
                rdata_q <= mem_rdata;
                mem_ren <= 1'b0;
                mem_wen <= 1'b0;
            end
        end
    end

    assign i_rdata = rdata_q;
    assign d_rdata = rdata_q;
endmodule
